pixel_scan_sequencer: RTL and testbench

//  Frame-level scheduler for the pixel SPI readout engine. Walks pixel addresses
//  0..PIXEL_NUM-1 and issues one read request per sample. Averages AVG_NUM ADC

---
 rtl/pixel_scan_sequencer_pkg.sv | 27 ++
 rtl/pixel_avg_acc.sv | 48 ++++
 rtl/pixel_scan_sequencer.sv | 149 ++++++++++++++
 tb/tb_pixel_scan_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_scan_sequencer_pkg.sv
// Shared types and sizing helpers for the pixel scan sequencer and its averager.
package pixel_scan_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StAccum,
    StPush,
    StNext
  } state_e;

  localparam int unsigned DefPixelNum   = 16;
  localparam int unsigned DefAddrWidth  = 8;
  localparam int unsigned DefAdcBits    = 18;
  localparam int unsigned DefAvgLog2    = 2;
  localparam int unsigned DefTimeoutCyc = 1024;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefTimeoutCntW = cnt_width(DefTimeoutCyc);
  localparam int unsigned DefResWidth    = DefAddrWidth + DefAdcBits + 1;

endpackage

// File: rtl/pixel_avg_acc.sv
// Per-pixel sample accumulator: sums signed samples, counts them, presents the floor average.
module pixel_avg_acc
  import pixel_scan_sequencer_pkg::*;
#(
  parameter int unsigned ADC_BITS = DefAdcBits,
  parameter int unsigned AVG_LOG2 = DefAvgLog2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                add,
  input  logic [ADC_BITS-1:0] sample,
  input  logic                step,
  output logic                last,
  output logic [ADC_BITS-1:0] avg
);

  localparam int unsigned AccW   = ADC_BITS + AVG_LOG2;
  localparam int unsigned AvgNum = 1 << AVG_LOG2;
  localparam int unsigned CntW   = cnt_width(AvgNum);

  logic signed [AccW-1:0] acc;
  logic signed [AccW-1:0] sample_ext;
  logic        [CntW-1:0] sample_cnt;

  assign sample_ext = AccW'($signed(sample));
  assign last       = (sample_cnt == CntW'(AvgNum - 1));
  // Arithmetic shift of the signed sum rounds toward -inf.
  assign avg        = ADC_BITS'(acc >>> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (clear) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else begin
      if (add) begin
        acc <= acc + sample_ext;
      end
      if (step) begin
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Frame scheduler: walks pixel addresses, requests AVG_NUM samples each, and pushes averages.
module pixel_scan_sequencer
  import pixel_scan_sequencer_pkg::*;
#(
  parameter int unsigned PIXEL_NUM   = DefPixelNum,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned ADC_BITS    = DefAdcBits,
  parameter int unsigned AVG_LOG2    = DefAvgLog2,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                  clk_ext,
  input  logic                  rstb_ext,
  input  logic                  scan_start,
  input  logic                  scan_continue,
  input  logic                  rotate_cfg,
  input  logic                  adc_int_cfg,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] pixel_select,
  output logic                  rotate_flag,
  output logic                  adc_int_flag,
  input  logic                  rd_done,
  input  logic [ADC_BITS-1:0]   adc_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [ADC_BITS-1:0]   res_data,
  output logic                  res_err,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned TmoW = cnt_width(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(PIXEL_NUM - 1);

  state_e                  state;
  logic [TmoW-1:0]         tmo_cnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    acc_clear, acc_add, acc_step, acc_last;
  logic [ADC_BITS-1:0]     acc_avg;

  // addr is held at 0 whenever the FSM is idle, so it can drive the select directly.
  assign pixel_select = addr;
  assign busy         = (state != StIdle);

  assign acc_clear = (state == StIdle) || (state == StNext);
  assign acc_add   = (state == StWait) && rd_done;
  assign acc_step  = (state == StAccum) && !acc_last;

  pixel_avg_acc #(
    .ADC_BITS(ADC_BITS),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk   (clk_ext),
    .rst_n (rstb_ext),
    .clear (acc_clear),
    .add   (acc_add),
    .sample(adc_data),
    .step  (acc_step),
    .last  (acc_last),
    .avg   (acc_avg)
  );

  always_ff @(posedge clk_ext or negedge rstb_ext) begin
    if (!rstb_ext) begin
      state        <= StIdle;
      tmo_cnt      <= '0;
      addr         <= '0;
      rd_req       <= 1'b0;
      rotate_flag  <= 1'b0;
      adc_int_flag <= 1'b0;
      res_valid    <= 1'b0;
      res_addr     <= '0;
      res_data     <= '0;
      res_err      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      rd_req     <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (scan_start) begin
            rotate_flag  <= rotate_cfg;
            adc_int_flag <= adc_int_cfg;
            addr         <= '0;
            rd_req       <= 1'b1;
            state        <= StIssue;
          end
        end
        StIssue: begin
          tmo_cnt <= '0;
          state   <= StWait;
        end
        StWait: begin
          if (rd_done) begin
            state <= StAccum;
          end else if (tmo_cnt == TmoLast) begin
            // Abandon this pixel; the engine is left as is and the next pixel starts fresh.
            res_valid <= 1'b1;
            res_addr  <= addr;
            res_data  <= '0;
            res_err   <= 1'b1;
            state     <= StPush;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StAccum: begin
          if (acc_last) begin
            res_valid <= 1'b1;
            res_addr  <= addr;
            res_data  <= acc_avg;
            res_err   <= 1'b0;
            state     <= StPush;
          end else begin
            rd_req <= 1'b1;
            state  <= StIssue;
          end
        end
        StPush: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= StNext;
          end
        end
        StNext: begin
          if (addr != AddrLast) begin
            addr   <= addr + 1'b1;
            rd_req <= 1'b1;
            state  <= StIssue;
          end else begin
            frame_done <= 1'b1;
            addr       <= '0;
            if (scan_continue) begin
              rotate_flag  <= rotate_cfg;
              adc_int_flag <= adc_int_cfg;
              rd_req       <= 1'b1;
              state        <= StIssue;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Randomised scoreboard bench for pixel_scan_sequencer with a behavioural readout engine.
module tb_pixel_scan_sequencer;

  localparam int PixelNum   = 16;
  localparam int AddrW      = 8;
  localparam int AdcBits    = 18;
  localparam int AvgLog2    = 2;
  localparam int TimeoutCyc = 1024;
  localparam int AvgNum     = 1 << AvgLog2;

  logic               clk_ext = 1'b0;
  logic               rstb_ext = 1'b1;
  logic               scan_start = 1'b0, scan_continue = 1'b0;
  logic               rotate_cfg = 1'b0, adc_int_cfg = 1'b0;
  logic               rd_done = 1'b0, res_ready = 1'b0;
  logic [AdcBits-1:0] adc_data = '0;
  logic               rd_req, rotate_flag, adc_int_flag, res_valid, res_err, busy, frame_done;
  logic [AddrW-1:0]   pixel_select, res_addr;
  logic [AdcBits-1:0] res_data;

  pixel_scan_sequencer #(
    .PIXEL_NUM  (PixelNum),
    .ADDR_WIDTH (AddrW),
    .ADC_BITS   (AdcBits),
    .AVG_LOG2   (AvgLog2),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk_ext      (clk_ext),
    .rstb_ext     (rstb_ext),
    .scan_start   (scan_start),
    .scan_continue(scan_continue),
    .rotate_cfg   (rotate_cfg),
    .adc_int_cfg  (adc_int_cfg),
    .rd_req       (rd_req),
    .pixel_select (pixel_select),
    .rotate_flag  (rotate_flag),
    .adc_int_flag (adc_int_flag),
    .rd_done      (rd_done),
    .adc_data     (adc_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_addr     (res_addr),
    .res_data     (res_data),
    .res_err      (res_err),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk_ext = ~clk_ext;

  typedef struct {
    int addr;
    int data;
    bit err;
  } exp_t;

  exp_t               exp_q[$];
  int                 directed_q[$];
  int                 checks = 0, failures = 0;
  int                 accepts = 0, frames = 0;
  int                 model_addr = 0, model_cnt = 0, model_sum = 0;
  int                 drop_addr = -1;
  int                 eng_wait = -1;
  int                 ready_mode = 0;
  logic [AdcBits-1:0] eng_sample = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_advance();
    model_cnt  = 0;
    model_sum  = 0;
    model_addr = (model_addr + 1) % PixelNum;
  endtask

  // Reference: each pixel yields floor(sum of its samples / AvgNum), or an error record.
  task automatic model_request();
    int   s;
    exp_t e;
    check("pixel_select", int'(pixel_select), model_addr);
    if (model_addr == drop_addr && model_cnt == 0) begin
      drop_addr = -1;
      e.addr = model_addr; e.data = 0; e.err = 1'b1;
      exp_q.push_back(e);
      model_advance();
    end else begin
      if (directed_q.size() > 0) s = directed_q.pop_front();
      else s = int'($urandom_range(0, (1 << AdcBits) - 1)) - (1 << (AdcBits - 1));
      eng_sample = s[AdcBits-1:0];
      eng_wait   = int'($urandom_range(0, 3));
      model_sum += s;
      model_cnt++;
      if (model_cnt == AvgNum) begin
        e.addr = model_addr; e.data = floor_div(model_sum, AvgNum); e.err = 1'b0;
        exp_q.push_back(e);
        model_advance();
      end
    end
  endtask

  // Readout engine: answers each rd_req after a random delay unless told to drop it.
  initial begin
    forever begin
      @(posedge clk_ext);
      #1;
      rd_done = 1'b0;
      if (!rstb_ext) begin
        eng_wait = -1;
        continue;
      end
      if (eng_wait > 0) eng_wait--;
      else if (eng_wait == 0) begin
        rd_done  = 1'b1;
        adc_data = eng_sample;
        eng_wait = -1;
      end
      if (rd_req) model_request();
    end
  end

  initial begin
    forever begin
      @(posedge clk_ext);
      #1;
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ($urandom_range(0, 3) != 0);
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted result is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_ext);
      if (rstb_ext && frame_done) frames++;
      if (rstb_ext && res_valid && res_ready) begin
        accepts++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got addr %0d expected none", res_addr);
        end else begin
          e = exp_q.pop_front();
          check("res_addr", int'(res_addr), e.addr);
          check("res_data", int'($signed(res_data)), e.data);
          check("res_err", int'(res_err), int'(e.err));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_ext);
    #1;
  endtask

  task automatic wait_frame_done(input int bound, input string name);
    int f0;
    f0 = frames;
    for (int i = 0; i < bound && frames == f0; i++) tick();
    check(name, frames - f0, 1);
  endtask

  initial begin
    int a0, nreq, found;
    logic             stable;
    logic [AddrW-1:0] h_addr;
    logic [AdcBits-1:0] h_data;
    logic             h_err;

    directed_q = '{100, 101, 102, 103, -3, -4, -4, -4};
    drop_addr  = 5;
    #2 rstb_ext = 1'b0;
    repeat (3) tick();
    check("rst_rd_req", int'(rd_req), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pixel_select", int'(pixel_select), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_res_data", int'(res_data), 0);
    rstb_ext = 1'b1;
    repeat (3) tick();
    check("idle_busy", int'(busy), 0);

    // Frame 1: single frame, random backpressure, timeout on pixel 5.
    ready_mode = 1;
    scan_continue = 1'b0; rotate_cfg = 1'b1; adc_int_cfg = 1'b1; scan_start = 1'b1;
    tick();
    scan_start = 1'b0; rotate_cfg = 1'b0; adc_int_cfg = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_rd_req", int'(rd_req), 1);
    check("start_rotate_flag", int'(rotate_flag), 1);
    check("start_adc_int_flag", int'(adc_int_flag), 1);
    wait_frame_done(8000, "frame1_done");
    check("frame1_busy_low", int'(busy), 0);
    check("frame1_accepts", accepts, PixelNum);
    check("frame1_queue_empty", exp_q.size(), 0);
    repeat (10) tick();
    check("frame1_single_pulse", frames, 1);
    check("frame1_idle_rd_req", int'(rd_req), 0);

    // Frame 2: continuous scan; flags change mid-frame; long stall in PUSH.
    ready_mode = 0;
    scan_continue = 1'b1; rotate_cfg = 1'b0; adc_int_cfg = 1'b0; scan_start = 1'b1;
    tick();
    scan_start = 1'b0; rotate_cfg = 1'b1; adc_int_cfg = 1'b1;
    ready_mode = 2;
    found = 0;
    for (int i = 0; i < 500 && found == 0; i++) begin
      tick();
      if (res_valid && !res_ready) found = 1;
    end
    check("stall_reached", found, 1);
    h_addr = res_addr; h_data = res_data; h_err = res_err;
    stable = 1'b1;
    nreq = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!res_valid || res_addr != h_addr || res_data != h_data || res_err != h_err) stable = 0;
      if (rd_req) nreq++;
    end
    check("stall_stable", int'(stable), 1);
    check("stall_rd_req", nreq, 0);
    a0 = accepts;
    ready_mode = 0;
    tick();
    tick();
    check("stall_one_accept", accepts - a0, 1);
    check("stall_valid_drop", int'(res_valid), 0);
    check("midframe_rotate_flag", int'(rotate_flag), 0);
    wait_frame_done(3000, "frame2_done");
    check("wrap_rotate_flag", int'(rotate_flag), 1);
    check("wrap_adc_int_flag", int'(adc_int_flag), 1);
    check("wrap_pixel_select", int'(pixel_select), 0);
    check("wrap_busy", int'(busy), 1);
    scan_continue = 1'b0;

    // Frame 3: reset while waiting on the engine.
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      tick();
      if (rd_req && pixel_select == AddrW'(2)) found = 1;
    end
    check("frame3_reach_pixel2", found, 1);
    tick();
    rstb_ext = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_pixel_select", int'(pixel_select), 0);
    check("arst_rotate_flag", int'(rotate_flag), 0);
    check("arst_adc_int_flag", int'(adc_int_flag), 0);
    check("arst_rd_req", int'(rd_req), 0);
    check("arst_res_valid", int'(res_valid), 0);
    exp_q.delete();
    model_addr = 0; model_cnt = 0; model_sum = 0; drop_addr = -1;
    repeat (3) tick();
    rstb_ext = 1'b1;
    repeat (5) tick();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(res_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
